// File: rtl/move_scheduler.sv
// Direction-command scheduler for the 2048 engine: merges keyboard and button
// strobes into a small FIFO and sequences move / spawn handshakes one at a time.
module move_scheduler #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [3:0]  PLAY_MODE = 4'd1,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kbd_valid,
    input  logic [3:0] kbd_dir,
    input  logic       btn_valid,
    input  logic [3:0] btn_dir,
    input  logic [3:0] mode,
    input  logic       mv_done,
    input  logic       mv_changed,
    input  logic       spawn_done,
    output logic       mv_start,
    output logic [3:0] mv_dir,
    output logic       spawn_start,
    output logic       busy,
    output logic [4:0] q_count,
    output logic       drop,
    output logic       err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_MV,
        SPAWN,
        WAIT_SP
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_inc;
    logic [4:0]    count, free;
    logic          rr;
    logic [WW-1:0] wd_cnt;

    logic       kbd_ok, btn_ok, play, pop, drop_nx, timeout;
    logic [1:0] n_push;
    logic [3:0] first_dir, second_dir;

    // Admission: free space is judged before any same-cycle pop.
    always_comb begin
        kbd_ok     = kbd_valid && $onehot(kbd_dir);
        btn_ok     = btn_valid && $onehot(btn_dir);
        play       = (mode == PLAY_MODE);
        free       = 5'(DEPTH) - count;
        wr_ptr_inc = wr_ptr + 1'b1;
        second_dir = rr ? kbd_dir : btn_dir;
        if (kbd_ok && btn_ok) first_dir = rr ? btn_dir : kbd_dir;
        else if (btn_ok)      first_dir = btn_dir;
        else                  first_dir = kbd_dir;
        n_push  = 2'd0;
        drop_nx = 1'b0;
        if (play) begin
            if (kbd_ok && btn_ok) begin
                if (free >= 5'd2) begin
                    n_push = 2'd2;
                end else if (free == 5'd1) begin
                    n_push  = 2'd1;
                    drop_nx = 1'b1;
                end else begin
                    drop_nx = 1'b1;
                end
            end else if (kbd_ok || btn_ok) begin
                if (free != 5'd0) n_push = 2'd1;
                else              drop_nx = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        timeout  = 1'b0;
        case (state)
            IDLE:    if (count != 5'd0 && play) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT_MV;
            WAIT_MV: begin
                if (mv_done) begin
                    state_nx = mv_changed ? SPAWN : IDLE;
                end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
                    timeout  = 1'b1;
                    state_nx = IDLE;
                end
            end
            SPAWN:   state_nx = WAIT_SP;
            WAIT_SP: begin
                if (spawn_done) begin
                    state_nx = IDLE;
                end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
                    timeout  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The head is popped on the edge into ISSUE so mv_dir is valid alongside mv_start.
    assign pop         = (state == IDLE) && (state_nx == ISSUE);
    assign mv_start    = (state == ISSUE);
    assign spawn_start = (state == SPAWN);
    assign busy        = (state != IDLE);
    assign q_count     = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= timeout;
            if (state == WAIT_MV || state == WAIT_SP) wd_cnt <= wd_cnt + 1'b1;
            else                                      wd_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (play && n_push != 2'd0) mem[wr_ptr] <= first_dir;
        if (play && n_push == 2'd2) mem[wr_ptr_inc] <= second_dir;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr     <= 1'b0;
            drop   <= 1'b0;
            mv_dir <= '0;
        end else begin
            drop <= drop_nx;
            if (pop) mv_dir <= mem[rd_ptr];
            if (!play) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                wr_ptr <= wr_ptr + AW'(n_push);
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + 5'(n_push) - 5'(pop);
                if (kbd_ok && btn_ok) rr <= ~rr;
            end
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed self-checking bench for move_scheduler: one task per scenario,
// expected values hand-derived from the cycle-level behaviour of the scheduler.
module tb_move_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       kbd_valid, btn_valid;
    logic [3:0] kbd_dir, btn_dir, mode;
    logic       mv_done, mv_changed, spawn_done;
    logic       mv_start, spawn_start, busy, drop, err;
    logic [3:0] mv_dir;
    logic [4:0] q_count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned start_cnt = 0;

    always #5 clk = ~clk;

    move_scheduler #(
        .DEPTH(4),
        .PLAY_MODE(4'd1),
        .TIMEOUT(12)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .kbd_valid(kbd_valid),
        .kbd_dir(kbd_dir),
        .btn_valid(btn_valid),
        .btn_dir(btn_dir),
        .mode(mode),
        .mv_done(mv_done),
        .mv_changed(mv_changed),
        .spawn_done(spawn_done),
        .mv_start(mv_start),
        .mv_dir(mv_dir),
        .spawn_start(spawn_start),
        .busy(busy),
        .q_count(q_count),
        .drop(drop),
        .err(err)
    );

    always @(negedge clk) if (mv_start === 1'b1) start_cnt++;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        kbd_valid  = 1'b0;
        btn_valid  = 1'b0;
        kbd_dir    = 4'b0000;
        btn_dir    = 4'b0000;
        mv_done    = 1'b0;
        mv_changed = 1'b0;
        spawn_done = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        mode  = 4'd1;
        rst_n = 1'b0;
        step(2);
        checks++;
        if ({mv_start, spawn_start, busy, q_count, drop, err, mv_dir} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {mv_start, spawn_start, busy, q_count, drop, err, mv_dir});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_move();
        kbd_valid = 1'b1; kbd_dir = 4'b0010;
        step();
        idle_inputs();
        checks++;
        if (q_count !== 5'd1 || mv_start !== 1'b0) begin
            errors++;
            $display("FAIL single_enqueue: q_count=%0d mv_start=%b expected 1,0", q_count, mv_start);
        end
        step();
        checks++;
        if (mv_start !== 1'b1 || mv_dir !== 4'b0010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: mv_start=%b mv_dir=%b busy=%b expected 1,0010,1",
                     mv_start, mv_dir, busy);
        end
        step();
        mv_done = 1'b1; mv_changed = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (spawn_start !== 1'b1 || mv_start !== 1'b0) begin
            errors++;
            $display("FAIL single_spawn: spawn_start=%b mv_start=%b expected 1,0", spawn_start, mv_start);
        end
        step();
        spawn_done = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (busy !== 1'b0 || mv_dir !== 4'b0010) begin
            errors++;
            $display("FAIL single_done: busy=%b mv_dir=%b expected 0,0010", busy, mv_dir);
        end
    endtask

    task automatic test_collision();
        logic [3:0] exp_order [4];
        exp_order[0] = 4'b1000; exp_order[1] = 4'b0001;
        exp_order[2] = 4'b0001; exp_order[3] = 4'b1000;
        for (int pair = 0; pair < 2; pair++) begin
            kbd_valid = 1'b1; kbd_dir = 4'b1000;
            btn_valid = 1'b1; btn_dir = 4'b0001;
            step();
            idle_inputs();
            checks++;
            if (q_count !== 5'd2) begin
                errors++;
                $display("FAIL collision_count%0d: q_count=%0d expected 2", pair, q_count);
            end
            for (int k = 0; k < 2; k++) begin
                step();
                checks++;
                if (mv_start !== 1'b1 || mv_dir !== exp_order[pair*2+k]) begin
                    errors++;
                    $display("FAIL collision_order%0d: mv_start=%b mv_dir=%b expected 1,%b",
                             pair*2+k, mv_start, mv_dir, exp_order[pair*2+k]);
                end
                step();
                mv_done = 1'b1; mv_changed = 1'b0;
                step();
                idle_inputs();
                checks++;
                if (mv_start !== 1'b0 || spawn_start !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL nochange_idle%0d: mv_start=%b spawn_start=%b busy=%b expected 0,0,0",
                             pair*2+k, mv_start, spawn_start, busy);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [3:0] exp_q [4];
        exp_q[0] = 4'b0100; exp_q[1] = 4'b1000; exp_q[2] = 4'b0001; exp_q[3] = 4'b0100;
        kbd_valid = 1'b1; kbd_dir = 4'b0010;
        step();
        idle_inputs(); kbd_valid = 1'b1; kbd_dir = 4'b0100;
        step();
        idle_inputs(); btn_valid = 1'b1; btn_dir = 4'b1000;
        checks++;
        if (mv_start !== 1'b1 || mv_dir !== 4'b0010 || q_count !== 5'd1) begin
            errors++;
            $display("FAIL full_first_issue: mv_start=%b mv_dir=%b q_count=%0d expected 1,0010,1",
                     mv_start, mv_dir, q_count);
        end
        step();
        idle_inputs(); kbd_valid = 1'b1; kbd_dir = 4'b0001;
        step();
        idle_inputs(); btn_valid = 1'b1; btn_dir = 4'b0100;
        step();
        idle_inputs(); kbd_valid = 1'b1; kbd_dir = 4'b0010;
        checks++;
        if (q_count !== 5'd4 || drop !== 1'b0) begin
            errors++;
            $display("FAIL full_fill: q_count=%0d drop=%b expected 4,0", q_count, drop);
        end
        step();
        idle_inputs();
        checks++;
        if (drop !== 1'b1 || q_count !== 5'd4) begin
            errors++;
            $display("FAIL full_drop: drop=%b q_count=%0d expected 1,4", drop, q_count);
        end
        step();
        checks++;
        if (drop !== 1'b0) begin
            errors++;
            $display("FAIL full_drop_width: drop=%b expected 0", drop);
        end
        mv_done = 1'b1;
        step();
        idle_inputs();
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mv_start !== 1'b1 || mv_dir !== exp_q[i] || q_count !== 5'(3 - i)) begin
                errors++;
                $display("FAIL full_order%0d: mv_start=%b mv_dir=%b q_count=%0d expected 1,%b,%0d",
                         i, mv_start, mv_dir, q_count, exp_q[i], 3 - i);
            end
            step();
            mv_done = 1'b1;
            step();
            idle_inputs();
            step();
        end
        checks++;
        if (busy !== 1'b0 || q_count !== 5'd0) begin
            errors++;
            $display("FAIL full_drained: busy=%b q_count=%0d expected 0,0", busy, q_count);
        end
    endtask

    task automatic test_ignored();
        kbd_valid = 1'b1; kbd_dir = 4'b0110;
        btn_valid = 1'b1; btn_dir = 4'b0000;
        mv_done = 1'b1; mv_changed = 1'b1; spawn_done = 1'b1;
        step();
        idle_inputs();
        checks++;
        if ({q_count, drop, busy, mv_start, spawn_start} !== 9'd0) begin
            errors++;
            $display("FAIL malformed_ignored: q_count=%0d drop=%b busy=%b mv_start=%b spawn_start=%b expected all 0",
                     q_count, drop, busy, mv_start, spawn_start);
        end
        step();
        checks++;
        if (busy !== 1'b0 || spawn_start !== 1'b0) begin
            errors++;
            $display("FAIL stray_done: busy=%b spawn_start=%b expected 0,0", busy, spawn_start);
        end
    endtask

    task automatic test_timeout();
        kbd_valid = 1'b1; kbd_dir = 4'b0010;
        btn_valid = 1'b1; btn_dir = 4'b0100;
        step();
        idle_inputs();
        step();
        checks++;
        if (mv_start !== 1'b1 || mv_dir !== 4'b0010) begin
            errors++;
            $display("FAIL timeout_issue: mv_start=%b mv_dir=%b expected 1,0010", mv_start, mv_dir);
        end
        step(12);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_last_wait: busy=%b err=%b expected 1,0", busy, err);
        end
        step();
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || q_count !== 5'd1) begin
            errors++;
            $display("FAIL timeout_abort: err=%b busy=%b q_count=%0d expected 1,0,1", err, busy, q_count);
        end
        step();
        checks++;
        if (err !== 1'b0 || mv_start !== 1'b1 || mv_dir !== 4'b0100) begin
            errors++;
            $display("FAIL timeout_resume: err=%b mv_start=%b mv_dir=%b expected 0,1,0100",
                     err, mv_start, mv_dir);
        end
        step();
        mv_done = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_mode_flush();
        int unsigned starts_before;
        kbd_valid = 1'b1; kbd_dir = 4'b1000;
        step();
        kbd_dir = 4'b0001;
        step();
        kbd_dir = 4'b0100;
        step();
        kbd_dir = 4'b0010;
        step();
        idle_inputs();
        checks++;
        if (q_count !== 5'd3 || busy !== 1'b1 || mv_dir !== 4'b1000) begin
            errors++;
            $display("FAIL flush_setup: q_count=%0d busy=%b mv_dir=%b expected 3,1,1000",
                     q_count, busy, mv_dir);
        end
        mode = 4'd2;
        starts_before = start_cnt;
        step();
        checks++;
        if (q_count !== 5'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_count: q_count=%0d busy=%b expected 0,1", q_count, busy);
        end
        mv_done = 1'b1; mv_changed = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (spawn_start !== 1'b1) begin
            errors++;
            $display("FAIL flush_inflight_spawn: spawn_start=%b expected 1", spawn_start);
        end
        step();
        spawn_done = 1'b1;
        step();
        idle_inputs();
        kbd_valid = 1'b1; kbd_dir = 4'b1000;
        step();
        idle_inputs();
        checks++;
        if (q_count !== 5'd0 || drop !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard: q_count=%0d drop=%b busy=%b expected 0,0,0", q_count, drop, busy);
        end
        step(5);
        mode = 4'd1;
        step(3);
        checks++;
        if (start_cnt !== starts_before) begin
            errors++;
            $display("FAIL flush_no_start: mv_start pulses=%0d expected 0", start_cnt - starts_before);
        end
    endtask

    task automatic test_reset_mid();
        kbd_valid = 1'b1; kbd_dir = 4'b1000;
        step();
        idle_inputs(); btn_valid = 1'b1; btn_dir = 4'b0001;
        step();
        idle_inputs();
        step();
        mv_done = 1'b1; mv_changed = 1'b1;
        step();
        idle_inputs();
        step();
        checks++;
        if (busy !== 1'b1 || q_count !== 5'd1 || mv_dir !== 4'b1000 || spawn_start !== 1'b0) begin
            errors++;
            $display("FAIL midreset_setup: busy=%b q_count=%0d mv_dir=%b spawn_start=%b expected 1,1,1000,0",
                     busy, q_count, mv_dir, spawn_start);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({mv_start, spawn_start, busy, q_count, drop, err, mv_dir} !== 14'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected all zero",
                     {mv_start, spawn_start, busy, q_count, drop, err, mv_dir});
        end
        rst_n = 1'b1;
        kbd_valid = 1'b1; kbd_dir = 4'b0010;
        btn_valid = 1'b1; btn_dir = 4'b0100;
        step();
        idle_inputs();
        step();
        checks++;
        if (mv_start !== 1'b1 || mv_dir !== 4'b0010) begin
            errors++;
            $display("FAIL midreset_rr: mv_start=%b mv_dir=%b expected 1,0010", mv_start, mv_dir);
        end
        step();
        mv_done = 1'b1;
        step();
        idle_inputs();
        step(3);
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_collision();
        test_fifo_full();
        test_ignored();
        test_timeout();
        test_mode_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
